// File: rtl/anton_neopixel_sequencer.sv
// Frame sequencer for the NeoPixel stream stage: walks pixel/bit/slot indices and times the inter-frame latch gap.
// Optional build macro NEOPIXEL_SEQ_FRAME_LATCH_EN freezes regCtrl32bit/regCtrlLimit for the duration of each frame.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b0
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b1
`endif

module anton_neopixel_sequencer #(
  parameter int BUFFER_END = `BUFFER_END_DEFAULT,
  parameter int RESET_DELAY = 600,
  localparam int BUFFER_BITS = `CLOG2(BUFFER_END+1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   rst,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlLoop,
  input  logic                   regCtrl32bit,
  input  logic [BUFFER_BITS-1:0] regCtrlLimit,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixelIndex,
  output logic [4:0]             pixelBitIndex,
  output logic [2:0]             bitPatternIndex,
  output logic                   streamDone
);

  localparam logic [9:0] GAP_LAST = 10'(RESET_DELAY - 1);
  localparam logic [BUFFER_BITS-1:0] END_ADDR = BUFFER_BITS'(BUFFER_END);

  logic                   stateNext;
  logic [9:0]             gapCnt, gapCntNext;
  logic                   armed, armedNext;
  logic                   runPrev;
  logic [BUFFER_BITS-1:0] pixelIndexNext;
  logic [4:0]             pixelBitIndexNext;
  logic [2:0]             bitPatternIndexNext;
  logic                   streamDoneNext;

  logic                   mode32;
  logic [BUFFER_BITS-1:0] limSel, limEff, pixStep;
  logic                   runRise, gapDone, startFrame;
  logic                   bitWrap, pixelWrap, lastPixel, frameEnd, abortFrame;

`ifdef NEOPIXEL_SEQ_FRAME_LATCH_EN
  logic                   mode32Sh;
  logic [BUFFER_BITS-1:0] limSh;

  always_ff @(posedge clk6_4mhz or posedge rst) begin
    if (rst) begin
      mode32Sh <= 1'b0;
      limSh    <= '0;
    end else if (startFrame) begin
      mode32Sh <= regCtrl32bit;
      limSh    <= regCtrlLimit;
    end
  end

  assign mode32 = mode32Sh;
  assign limSel = limSh;
`else
  assign mode32 = regCtrl32bit;
  assign limSel = regCtrlLimit;
`endif

  assign limEff  = (limSel > END_ADDR) ? END_ADDR : limSel;
  assign runRise = regCtrlRun & ~runPrev;
  assign gapDone = (gapCnt == GAP_LAST);

  // A run edge seen on the saturating cycle counts as armed immediately.
  assign startFrame = (state == `ENUM_STATE_RESET) && gapDone && regCtrlRun &&
                      (regCtrlLoop || armed || runRise);

  assign bitWrap   = (bitPatternIndex == 3'd7);
  assign pixelWrap = bitWrap && (pixelBitIndex == 5'd23);

  // Greater-or-equal keeps a live limit lowered below the current pixel from running past the buffer.
  assign lastPixel = mode32 ? (pixelIndex[BUFFER_BITS-1:2] >= limEff[BUFFER_BITS-1:2])
                            : (pixelIndex >= limEff);
  assign pixStep   = mode32 ? {pixelIndex[BUFFER_BITS-1:2] + (BUFFER_BITS-2)'(1), 2'b00}
                            : pixelIndex + BUFFER_BITS'(1);

  assign abortFrame = (state == `ENUM_STATE_TRANSMIT) && !regCtrlRun;
  assign frameEnd   = (state == `ENUM_STATE_TRANSMIT) && regCtrlRun && pixelWrap && lastPixel;

  always_ff @(posedge clk6_4mhz or posedge rst) begin
    if (rst) state <= `ENUM_STATE_RESET;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == `ENUM_STATE_RESET) begin
      if (startFrame) stateNext = `ENUM_STATE_TRANSMIT;
    end else begin
      if (abortFrame || frameEnd) stateNext = `ENUM_STATE_RESET;
    end
  end

  always_comb begin
    gapCntNext          = gapCnt;
    armedNext           = armed;
    pixelIndexNext      = pixelIndex;
    pixelBitIndexNext   = pixelBitIndex;
    bitPatternIndexNext = bitPatternIndex;
    streamDoneNext      = 1'b0;

    if (state == `ENUM_STATE_RESET) begin
      pixelIndexNext      = '0;
      pixelBitIndexNext   = '0;
      bitPatternIndexNext = '0;
      if (!gapDone) gapCntNext = gapCnt + 10'd1;
      if (runRise)  armedNext  = 1'b1;
      if (startFrame) begin
        gapCntNext = '0;
        armedNext  = 1'b0;
      end
    end else if (abortFrame || frameEnd) begin
      pixelIndexNext      = '0;
      pixelBitIndexNext   = '0;
      bitPatternIndexNext = '0;
      gapCntNext          = '0;
      streamDoneNext      = frameEnd;
    end else begin
      bitPatternIndexNext = bitPatternIndex + 3'd1;
      if (bitWrap) begin
        if (pixelWrap) begin
          pixelBitIndexNext = '0;
          pixelIndexNext    = pixStep;
        end else begin
          pixelBitIndexNext = pixelBitIndex + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk6_4mhz or posedge rst) begin
    if (rst) begin
      gapCnt          <= '0;
      armed           <= 1'b0;
      runPrev         <= 1'b0;
      pixelIndex      <= '0;
      pixelBitIndex   <= '0;
      bitPatternIndex <= '0;
      streamDone      <= 1'b0;
    end else begin
      gapCnt          <= gapCntNext;
      armed           <= armedNext;
      runPrev         <= regCtrlRun;
      pixelIndex      <= pixelIndexNext;
      pixelBitIndex   <= pixelBitIndexNext;
      bitPatternIndex <= bitPatternIndexNext;
      streamDone      <= streamDoneNext;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_sequencer.sv
// Directed bench for anton_neopixel_sequencer (BUFFER_END=9, RESET_DELAY=600).
// Cycle n means the falling edge after the n-th rising edge following reset release.

module tb_anton_neopixel_sequencer;

  localparam logic ST_RESET = 1'b0;
  localparam logic ST_TX    = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, loop, m32;
  logic [3:0] limit;
  logic       state;
  logic [3:0] pixelIndex;
  logic [4:0] pixelBitIndex;
  logic [2:0] bitPatternIndex;
  logic       streamDone;

  int total = 0;
  int bad   = 0;

  anton_neopixel_sequencer #(.BUFFER_END(9), .RESET_DELAY(600)) dut (
    .clk6_4mhz       (clk),
    .rst             (rst),
    .regCtrlRun      (run),
    .regCtrlLoop     (loop),
    .regCtrl32bit    (m32),
    .regCtrlLimit    (limit),
    .state           (state),
    .pixelIndex      (pixelIndex),
    .pixelBitIndex   (pixelBitIndex),
    .bitPatternIndex (bitPatternIndex),
    .streamDone      (streamDone)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Walks a whole frame from its first TRANSMIT cycle, then the done cycle and the one after.
  task automatic run_frame(input int npix, input int step, input string name);
    logic [13:0] exp, act;
    int errs;
    errs = 0;
    for (int k = 0; k < npix * 192; k++) begin
      exp = {ST_TX, 4'((k / 192) * step), 5'((k % 192) / 8), 3'(k % 8), 1'b0};
      act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
      total++;
      if (act !== exp) begin
        bad++;
        if (errs < 5) $display("FAIL %s tx k=%0d: got %h want %h", name, k, act, exp);
        errs++;
      end
      tick(1);
    end
    act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
    total++;
    if (act !== {ST_RESET, 4'd0, 5'd0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL %s done: got %h want %h", name, act, {ST_RESET, 13'd1});
    end
    tick(1);
    total++;
    if ({state, streamDone} !== {ST_RESET, 1'b0}) begin
      bad++;
      $display("FAIL %s done_width: got state=%b done=%b want 0 0", name, state, streamDone);
    end
  endtask

  task automatic test_reset();
    run = 1'b0; loop = 1'b0; m32 = 1'b0; limit = 4'd0;
    rst = 1'b1;
    tick(2);
    total++;
    if ({state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone});
    end
    rst = 1'b0;
    tick(700);
    total++;
    if (state !== ST_RESET) begin
      bad++;
      $display("FAIL idle_no_run: got state=%b want 0", state);
    end
  endtask

  task automatic test_loop_8bit();
    run = 1'b1; loop = 1'b1; m32 = 1'b0; limit = 4'd2;
    do_reset();
    tick(599);
    total++;
    if (state !== ST_RESET) begin
      bad++;
      $display("FAIL loop_gap599: got state=%b want 0", state);
    end
    tick(1);
    run_frame(3, 1, "loop_f1");
    tick(598);
    total++;
    if (state !== ST_RESET) begin
      bad++;
      $display("FAIL loop_gap1775: got state=%b want 0", state);
    end
    tick(1);
    run_frame(3, 1, "loop_f2");
  endtask

  task automatic test_32bit();
    run = 1'b1; loop = 1'b1; m32 = 1'b1; limit = 4'd7;
    do_reset();
    tick(600);
    run_frame(2, 4, "mode32");
  endtask

  task automatic test_clamp();
    run = 1'b1; loop = 1'b1; m32 = 1'b0; limit = 4'd12;
    do_reset();
    tick(600);
    run_frame(10, 1, "clamp");
  endtask

  task automatic test_single_shot();
    int seen_tx;
    run = 1'b0; loop = 1'b0; m32 = 1'b0; limit = 4'd0;
    do_reset();
    tick(700);
    run = 1'b1;
    tick(1);
    run_frame(1, 1, "single1");
    seen_tx = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (state !== ST_RESET) seen_tx++;
    end
    total++;
    if (seen_tx !== 0) begin
      bad++;
      $display("FAIL single_hold: got %0d transmit cycles want 0", seen_tx);
    end
    run = 1'b0;
    tick(1);
    run = 1'b1;
    tick(1);
    run_frame(1, 1, "single2");
  endtask

  task automatic test_run_drop();
    logic [13:0] act;
    run = 1'b1; loop = 1'b1; m32 = 1'b0; limit = 4'd2;
    do_reset();
    tick(872);
    act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
    total++;
    if (act !== {ST_TX, 4'd1, 5'd10, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL drop_pre: got %h want %h", act, {ST_TX, 4'd1, 5'd10, 3'd0, 1'b0});
    end
    run = 1'b0;
    tick(1);
    act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
    total++;
    if (act !== 14'd0) begin
      bad++;
      $display("FAIL drop_post: got %h want 0", act);
    end
    run = 1'b1;
    tick(599);
    total++;
    if (state !== ST_RESET) begin
      bad++;
      $display("FAIL drop_gap: got state=%b want 0", state);
    end
    tick(1);
    total++;
    if (state !== ST_TX) begin
      bad++;
      $display("FAIL drop_restart: got state=%b want 1", state);
    end
  endtask

  task automatic test_live_limit();
    run = 1'b1; loop = 1'b1; m32 = 1'b0; limit = 4'd2;
    do_reset();
    tick(650);
    limit = 4'd0;
`ifdef NEOPIXEL_SEQ_FRAME_LATCH_EN
    tick(525);
    total++;
    if ({state, pixelIndex} !== {ST_TX, 4'd2}) begin
      bad++;
      $display("FAIL latch_last: got %b/%0d want 1/2", state, pixelIndex);
    end
    tick(1);
    total++;
    if ({state, streamDone} !== {ST_RESET, 1'b1}) begin
      bad++;
      $display("FAIL latch_done1: got %b/%b want 0/1", state, streamDone);
    end
    tick(600);
    total++;
    if (state !== ST_TX) begin
      bad++;
      $display("FAIL latch_start2: got state=%b want 1", state);
    end
    tick(192);
    total++;
    if ({state, streamDone} !== {ST_RESET, 1'b1}) begin
      bad++;
      $display("FAIL latch_done2: got %b/%b want 0/1", state, streamDone);
    end
`else
    tick(141);
    total++;
    if ({state, pixelIndex} !== {ST_TX, 4'd0}) begin
      bad++;
      $display("FAIL live_last: got %b/%0d want 1/0", state, pixelIndex);
    end
    tick(1);
    total++;
    if ({state, streamDone} !== {ST_RESET, 1'b1}) begin
      bad++;
      $display("FAIL live_done: got %b/%b want 0/1", state, streamDone);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [13:0] act;
    run = 1'b1; loop = 1'b1; m32 = 1'b0; limit = 4'd2;
    do_reset();
    tick(900);
    act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
    total++;
    if (act !== {ST_TX, 4'd1, 5'd13, 3'd4, 1'b0}) begin
      bad++;
      $display("FAIL async_pre: got %h want %h", act, {ST_TX, 4'd1, 5'd13, 3'd4, 1'b0});
    end
    #1;
    rst = 1'b1;
    #1;
    act = {state, pixelIndex, pixelBitIndex, bitPatternIndex, streamDone};
    total++;
    if (act !== 14'd0) begin
      bad++;
      $display("FAIL async_clear: got %h want 0", act);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loop_8bit();
    test_32bit();
    test_clamp();
    test_single_shot();
    test_run_drop();
    test_live_limit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
